// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer: round-robin arbiter that shares one bank of
// transparent-low latches among NUM_REQ requesters. Each transaction runs
// IDLE -> SETUP -> STROBE -> HOLD, with each phase lasting one clock.
// Data, gate, clear and preset never change on the same edge.
module latch_bank_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     op,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id,
    output logic [WIDTH-1:0]         latch_d,
    output logic                     latch_g,
    output logic                     latch_clr,
    output logic                     latch_pre
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_NOP    = 2'b11
    } op_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    op_t                  op_q, op_d;
    logic [WIDTH-1:0]     latch_d_q, latch_d_d;
    logic                 latch_g_q, latch_g_d;
    logic                 latch_clr_q, latch_clr_d;
    logic                 latch_pre_q, latch_pre_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic                 arb_found;
    logic [IDW-1:0]       arb_win;

    // Round-robin search: first active request starting at rr_q, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        arb_found = 1'b0;
        arb_win   = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req[(int'(rr_q) + i) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_win   = IDW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    // Next-state and next-output logic; every output is the registered
    // image of the value computed here for the state being entered.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_id_d  = grant_id_q;
        op_d        = op_q;
        latch_d_d   = latch_d_q;
        latch_g_d   = 1'b1;
        latch_clr_d = 1'b0;
        latch_pre_d = 1'b0;
        busy_d      = 1'b0;
        ack_d       = '0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = SETUP;
                    busy_d     = 1'b1;
                    grant_id_d = arb_win;
                    op_d       = op_t'(op[2*int'(arb_win) +: 2]);
                    rr_d       = IDW'((int'(arb_win) + 1) % NUM_REQ);
                    // Only loads drive new data; other ops leave D untouched.
                    if (op_t'(op[2*int'(arb_win) +: 2]) == OP_LOAD)
                        latch_d_d = wdata[WIDTH*int'(arb_win) +: WIDTH];
                end
            end
            SETUP: begin
                state_d = STROBE;
                busy_d  = 1'b1;
                ack_d[grant_id_q] = 1'b1;
                case (op_q)
                    OP_LOAD:   latch_g_d   = 1'b0;
                    OP_CLEAR:  latch_clr_d = 1'b1;
                    OP_PRESET: latch_pre_d = 1'b1;
                    default:   ;
                endcase
            end
            STROBE: begin
                state_d = HOLD;
                busy_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bank and drops any
    // transaction in flight without acking it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_id_q  <= '0;
            op_q        <= OP_NOP;
            latch_d_q   <= '0;
            latch_g_q   <= 1'b1;
            latch_clr_q <= 1'b1;
            latch_pre_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_id_q  <= grant_id_d;
            op_q        <= op_d;
            latch_d_q   <= latch_d_d;
            latch_g_q   <= latch_g_d;
            latch_clr_q <= latch_clr_d;
            latch_pre_q <= latch_pre_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign latch_d   = latch_d_q;
    assign latch_g   = latch_g_q;
    assign latch_clr = latch_clr_q;
    assign latch_pre = latch_pre_q;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed testbench for latch_bank_sequencer. Inputs change 1ns after a
// rising edge; outputs are sampled at that same point, away from the edge.
module tb_latch_bank_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  latch_d;
    logic        latch_g;
    logic        latch_clr;
    logic        latch_pre;

    int checks = 0;
    int errors = 0;

    latch_bank_sequencer #(.NUM_REQ(4), .WIDTH(8), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .ack       (ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .latch_d   (latch_d),
        .latch_g   (latch_g),
        .latch_clr (latch_clr),
        .latch_pre (latch_pre)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the full output set against expected values.
    task automatic expect_outs(input string name, input logic [3:0] e_ack,
                               input logic e_busy, input logic [7:0] e_d,
                               input logic e_g, input logic e_clr,
                               input logic e_pre);
        checks++;
        if ({ack, busy, latch_d, latch_g, latch_clr, latch_pre} !==
            {e_ack, e_busy, e_d, e_g, e_clr, e_pre}) begin
            errors++;
            $display("FAIL %s: got ack=%b busy=%b d=%h g=%b clr=%b pre=%b, want ack=%b busy=%b d=%h g=%b clr=%b pre=%b",
                     name, ack, busy, latch_d, latch_g, latch_clr, latch_pre,
                     e_ack, e_busy, e_d, e_g, e_clr, e_pre);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; op = 8'hFF; wdata = '0;
        tick(); tick();
        expect_outs("reset_held", 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d want 0", grant_id);
        end
        reset = 1'b0;
        tick();
        expect_outs("reset_release", 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset in the STROBE of a load from requester 2.
        req = 4'b0100; op = 8'h00; wdata = 32'h005A0000;
        tick();                         // SETUP
        req = '0;
        expect_outs("midrst_setup", 4'b0000, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        tick();                         // STROBE
        reset = 1'b1;
        tick();
        expect_outs("midrst_held", 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        expect_outs("midrst_release", 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_outs("midrst_idle", 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [1:0] ids   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] acks  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111; op = 8'h00; wdata = 32'h44332211;
        for (int n = 0; n < 5; n++) begin
            tick();                     // SETUP
            checks++;
            if (grant_id !== ids[n] || latch_d !== bytes[n]) begin
                errors++;
                $display("FAIL rr_grant%0d: got id=%0d d=%h want id=%0d d=%h",
                         n, grant_id, latch_d, ids[n], bytes[n]);
            end
            tick();                     // STROBE
            expect_outs($sformatf("rr_strobe%0d", n), acks[n], 1'b1, bytes[n],
                        1'b0, 1'b0, 1'b0);
            tick();                     // HOLD
            if (n == 4) req = '0;
            tick();                     // IDLE
        end
        expect_outs("rr_end_idle", 4'b0000, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_single_load();
        req = 4'b0100; op = 8'h00; wdata = 32'h00A50000;
        tick();                         // SETUP (E0+1)
        req = '0; wdata = '0;
        expect_outs("load_setup", 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (grant_id !== 2'd2) begin
            errors++;
            $display("FAIL load_grant_id: got %0d want 2", grant_id);
        end
        tick();                         // STROBE (E0+2)
        expect_outs("load_strobe", 4'b0100, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();                         // HOLD (E0+3)
        expect_outs("load_hold", 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();                         // IDLE (E0+4)
        expect_outs("load_idle", 4'b0000, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clear_preset();
        req = 4'b0001; op = 8'b11_11_11_01; wdata = 32'hFFFFFFFF;
        tick();
        req = '0;
        expect_outs("clr_setup", 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_outs("clr_strobe", 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        tick();
        expect_outs("clr_hold", 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();

        req = 4'b0010; op = 8'b11_11_10_11;
        tick();
        req = '0;
        tick();
        expect_outs("pre_strobe", 4'b0010, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outs("pre_hold", 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_outs("pre_idle", 4'b0000, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_noop_busy();
        req = 4'b1000; op = 8'b11_00_11_11; wdata = 32'h00_00_77_00;
        tick();                         // SETUP
        req = 4'b0010;                  // pulse confined to SETUP..HOLD
        tick();                         // STROBE
        expect_outs("nop_strobe", 4'b1000, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();                         // HOLD
        req = '0;
        tick();                         // IDLE
        for (int n = 0; n < 3; n++) begin
            tick();
            expect_outs($sformatf("busy_ignore%0d", n), 4'b0000, 1'b0, 8'hA5,
                        1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL nop_grant_id: got %0d want 3", grant_id);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_load();
        test_clear_preset();
        test_noop_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
